// File: rtl/arb_pkg.sv
// arb_pkg: shared types, defaults and the round-robin pick helper for rr_arbiter
package arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  localparam int ARB_N_DEF = 8;
  localparam int ARB_HOLD_DEF = 16;
  // Sized for the widest arbiter; narrower ones zero-extend, which keeps the search order intact.
  function automatic logic [ARB_N_DEF-1:0] rr_pick(input logic [ARB_N_DEF-1:0] req, input logic [2:0] ptr);
    logic [ARB_N_DEF-1:0] g;
    logic [2:0] j;
    g = '0;
    for (int k = ARB_N_DEF - 1; k >= 0; k--) begin
      j = ptr + 3'(k);
      if (req[j]) g = ARB_N_DEF'(1) << j;
    end
    return g;
  endfunction
endpackage

// File: rtl/onehot2bin.sv
// onehot2bin: one-hot to binary index encoder
module onehot2bin #(
  parameter int N = 8,
  parameter int IDXW = 3
) (
  input  logic [N-1:0]    onehot,
  output logic [IDXW-1:0] bin
);
  always_comb begin
    bin = '0;
    for (int i = 0; i < N; i++) bin |= {IDXW{onehot[i]}} & IDXW'(i);
  end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with registered one-hot grant and hold-limit preemption
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N = ARB_N_DEF,
  parameter int IDXW = $clog2(N),
  parameter int MAX_HOLD = ARB_HOLD_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_vld,
  output logic            preempt
);
  localparam int HW = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 1;
  arb_state_t state;
  logic [IDXW-1:0] ptr, nxt_idx;
  logic [HW-1:0] hold_cnt;
  logic [N-1:0] pick_idle, pick_next;
  logic rel, lim;
  onehot2bin #(.N(N), .IDXW(IDXW)) u_enc (.onehot(grant), .bin(grant_idx));
  assign grant_vld = |grant;
  assign nxt_idx = grant_idx + IDXW'(1);
  assign pick_idle = N'(rr_pick(ARB_N_DEF'(req), 3'(ptr)));
  assign pick_next = N'(rr_pick(ARB_N_DEF'(req), 3'(nxt_idx)));
  assign rel = state == ARB_BUSY && (req & grant) == '0;
  // Saturated counter still qualifies, so a late challenger preempts on its first pending edge.
  assign lim = MAX_HOLD != 0 && state == ARB_BUSY && !rel && hold_cnt >= HW'(MAX_HOLD - 1) && (req & ~grant) != '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      ptr <= '0;
      hold_cnt <= '0;
      grant <= '0;
      preempt <= 1'b0;
    end else begin
      preempt <= lim;
      if (state == ARB_IDLE) begin
        if (|req) begin
          grant <= pick_idle;
          state <= ARB_BUSY;
          hold_cnt <= '0;
        end
      end else if (rel || lim) begin
        ptr <= nxt_idx;
        grant <= pick_next;
        hold_cnt <= '0;
        state <= |pick_next ? ARB_BUSY : ARB_IDLE;
      end else begin
        hold_cnt <= hold_cnt != HW'(MAX_HOLD) ? hold_cnt + HW'(1) : hold_cnt;
      end
    end
  end
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed table and sequence checks for rr_arbiter (MAX_HOLD=4)
module tb_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] req = '0;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic grant_vld, preempt;
  int total = 0;
  int bad = 0;
  bit done = 0;
  rr_arbiter #(.N(8), .IDXW(3), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant),
    .grant_idx(grant_idx), .grant_vld(grant_vld), .preempt(preempt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] req;
    logic [7:0] g;
    logic [2:0] idx;
  } vec_t;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic expect_out(input string nm, input logic [7:0] g, input logic [2:0] i, input logic p);
    chk({nm, "_grant"}, 32'(grant), 32'(g));
    chk({nm, "_idx"}, 32'(grant_idx), 32'(i));
    chk({nm, "_vld"}, 32'(grant_vld), 32'(|g));
    chk({nm, "_preempt"}, 32'(preempt), 32'(p));
  endtask
  task automatic step(input logic [7:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_reset();
    req = '0;
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  always @(negedge clk) if (!rst && !done) chk("onehot0", 32'($onehot0(grant)), 32'd1);
  initial begin
    vec_t tbl[25];
    int npre;
    tbl = '{
      '{8'h20, 8'h20, 3'd5}, '{8'h00, 8'h00, 3'd0}, '{8'h41, 8'h40, 3'd6}, '{8'h41, 8'h40, 3'd6},
      '{8'h01, 8'h01, 3'd0}, '{8'h00, 8'h00, 3'd0}, '{8'h81, 8'h80, 3'd7}, '{8'h01, 8'h01, 3'd0},
      '{8'h00, 8'h00, 3'd0}, '{8'h40, 8'h40, 3'd6}, '{8'h00, 8'h00, 3'd0}, '{8'h81, 8'h80, 3'd7},
      '{8'h01, 8'h01, 3'd0}, '{8'h00, 8'h00, 3'd0}, '{8'h04, 8'h04, 3'd2}, '{8'h04, 8'h04, 3'd2},
      '{8'h12, 8'h10, 3'd4}, '{8'h00, 8'h00, 3'd0}, '{8'h24, 8'h20, 3'd5}, '{8'h04, 8'h04, 3'd2},
      '{8'h24, 8'h04, 3'd2}, '{8'h20, 8'h20, 3'd5}, '{8'h24, 8'h20, 3'd5}, '{8'h04, 8'h04, 3'd2},
      '{8'h00, 8'h00, 3'd0}
    };
    #1 expect_out("reset", 8'h00, 3'd0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(8'h04); expect_out("pre_rst_a", 8'h04, 3'd2, 1'b0);
    step(8'h00); expect_out("pre_rst_b", 8'h00, 3'd0, 1'b0);
    step(8'h04); expect_out("pre_rst_c", 8'h04, 3'd2, 1'b0);
    #2 rst = 1'b1;
    #1 expect_out("async_rst", 8'h00, 3'd0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(8'h05); expect_out("post_rst_ptr", 8'h01, 3'd0, 1'b0);
    step(8'h00); expect_out("post_rst_rel", 8'h00, 3'd0, 1'b0);
    foreach (tbl[k]) begin
      step(tbl[k].req);
      expect_out($sformatf("vec%0d", k), tbl[k].g, tbl[k].idx, 1'b0);
    end
    pulse_reset();
    step(8'hFF); expect_out("rot_first", 8'h01, 3'd0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step(8'hFF & ~(8'h01 << k));
      expect_out($sformatf("rot%0d", k), 8'h01 << ((k + 1) % 8), 3'((k + 1) % 8), 1'b0);
    end
    step(8'h00); expect_out("rot_end", 8'h00, 3'd0, 1'b0);
    step(8'h01); expect_out("hold_start", 8'h01, 3'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(8'h09);
      expect_out($sformatf("hold_keep%0d", k), 8'h01, 3'd0, 1'b0);
    end
    step(8'h09); expect_out("hold_preempt", 8'h08, 3'd3, 1'b1);
    step(8'h09); expect_out("hold_after", 8'h08, 3'd3, 1'b0);
    step(8'h01); expect_out("alone_start", 8'h01, 3'd0, 1'b0);
    npre = 0;
    for (int k = 0; k < 20; k++) begin
      step(8'h01);
      chk("alone_grant", 32'(grant), 32'h01);
      if (preempt) npre++;
    end
    chk("alone_no_preempt", 32'(npre), 32'd0);
    step(8'h05); expect_out("sat_preempt", 8'h04, 3'd2, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(8'h05);
      expect_out($sformatf("sat_keep%0d", k), 8'h04, 3'd2, 1'b0);
    end
    step(8'h01); expect_out("rel_and_limit", 8'h01, 3'd0, 1'b0);
    step(8'h00); expect_out("final_idle", 8'h00, 3'd0, 1'b0);
    done = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
